// File: rtl/mpmc9_app_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module   : mpmc9_app_cmd_issue
// Purpose  : Issues one MIG UI command per burst beat with app_rdy handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mpmc9_app_cmd_issue #(
  parameter int AW       = 29,
  parameter int BLW      = 6,
  parameter int ADDR_INC = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [2:0]     req_cmd,
  input  logic [AW-1:0]  req_addr,
  input  logic [BLW-1:0] req_len,
  input  logic           abort,
  input  logic           app_rdy,
  output logic           app_en,
  output logic [2:0]     app_cmd,
  output logic [AW-1:0]  app_addr,
  output logic           busy,
  output logic           done,
  output logic [BLW:0]   issued
);

  localparam logic [2:0] CMD_WRITE = 3'b000;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic           app_en_nxt;
  logic [2:0]     app_cmd_nxt;
  logic [AW-1:0]  app_addr_nxt;
  logic           done_nxt;
  logic [BLW:0]   issued_nxt;
  logic [BLW-1:0] remaining, remaining_nxt;
  logic           accept;

  assign accept    = app_en & app_rdy;
  assign req_ready = (state == IDLE);
  assign busy      = (state == ISSUE);

  always_comb begin
    state_nxt     = state;
    app_en_nxt    = app_en;
    app_cmd_nxt   = app_cmd;
    app_addr_nxt  = app_addr;
    done_nxt      = 1'b0;
    issued_nxt    = issued;
    remaining_nxt = remaining;
    case (state)
      IDLE: begin
        if (req_valid) begin
          app_cmd_nxt   = req_cmd;
          app_addr_nxt  = req_addr;
          remaining_nxt = req_len;
          issued_nxt    = '0;
          app_en_nxt    = 1'b1;
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        // abort only takes effect on an accept so a presented command is never withdrawn
        if (accept) begin
          issued_nxt = issued + {{BLW{1'b0}}, 1'b1};
          if ((remaining == '0) || abort) begin
            app_en_nxt = 1'b0;
            done_nxt   = 1'b1;
            state_nxt  = IDLE;
          end else begin
            remaining_nxt = remaining - {{(BLW-1){1'b0}}, 1'b1};
            app_addr_nxt  = app_addr + AW'(ADDR_INC);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      app_en    <= 1'b0;
      app_cmd   <= CMD_WRITE;
      app_addr  <= '0;
      done      <= 1'b0;
      issued    <= '0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      app_en    <= app_en_nxt;
      app_cmd   <= app_cmd_nxt;
      app_addr  <= app_addr_nxt;
      done      <= done_nxt;
      issued    <= issued_nxt;
      remaining <= remaining_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mpmc9_app_cmd_issue.sv
`default_nettype none
// Testbench for mpmc9_app_cmd_issue: directed plus randomized bursts, with a
// burst-level reference model checked every cycle by a monitor.
module tb_mpmc9_app_cmd_issue;

  localparam int AW       = 29;
  localparam int BLW      = 6;
  localparam int ADDR_INC = 8;

  logic           clk = 1'b0;
  logic           rstn;
  logic           req_valid;
  logic           req_ready;
  logic [2:0]     req_cmd;
  logic [AW-1:0]  req_addr;
  logic [BLW-1:0] req_len;
  logic           abort;
  logic           app_rdy;
  logic           app_en;
  logic [2:0]     app_cmd;
  logic [AW-1:0]  app_addr;
  logic           busy;
  logic           done;
  logic [BLW:0]   issued;

  mpmc9_app_cmd_issue #(.AW(AW), .BLW(BLW), .ADDR_INC(ADDR_INC)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_len(req_len), .abort(abort),
    .app_rdy(app_rdy), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .busy(busy), .done(done), .issued(issued)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cmd;
    longint      addr;
    int          len;
  } req_t;

  req_t req_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  // Reference model state: one burst at a time
  bit     m_active   = 1'b0;
  req_t   m_req;
  int     m_idx      = 0;
  int     m_issued   = 0;
  bit     m_done_exp = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint exp_addr(input longint base, input int idx);
    return (base + longint'(idx) * ADDR_INC) % (64'd1 << AW);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("req_ready", req_ready, !m_active);
        check("busy", busy, m_active);
        check("app_en", app_en, m_active);
        if (m_active) begin
          check("app_cmd", app_cmd, m_req.cmd);
          check("app_addr", app_addr, exp_addr(m_req.addr, m_idx));
        end
        check("done", done, m_done_exp);
        check("issued", issued, m_issued);
        m_done_exp = 1'b0;
        if (m_active) begin
          if (app_rdy) begin
            m_issued++;
            if (abort || m_idx == m_req.len) begin
              m_active   = 1'b0;
              m_done_exp = 1'b1;
            end else begin
              m_idx++;
            end
          end
        end else if (req_valid) begin
          if (req_q.size() == 0) begin
            fails++;
            tests++;
            $display("FAIL scoreboard: request latched with empty queue at %0t", $time);
          end else begin
            m_req    = req_q.pop_front();
            m_active = 1'b1;
            m_idx    = 0;
            m_issued = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fails++;
      tests++;
      $display("FAIL req_ready_timeout: got 0 expected 1 at %0t", $time);
    end
  endtask

  task automatic drive_req(input logic [2:0] cmd, input longint addr, input int len);
    req_t r;
    r.cmd = cmd; r.addr = addr; r.len = len;
    req_cmd   = cmd;
    req_addr  = AW'(addr);
    req_len   = BLW'(len);
    req_valid = 1'b1;
    req_q.push_back(r);
  endtask

  // abort_at < 0 means run to completion; stalls before each accept
  task automatic run_burst(input logic [2:0] cmd, input longint addr, input int len,
                           input int stall_max, input bit rnd, input int abort_at);
    int st;
    drive_req(cmd, addr, len);
    wait_ready();
    tick();
    req_valid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      st = rnd ? int'($urandom_range(0, stall_max)) : stall_max;
      app_rdy = 1'b0;
      for (int s = 0; s < st; s++) begin
        abort = (k == abort_at) ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
        tick();
      end
      abort   = (k == abort_at);
      app_rdy = 1'b1;
      tick();
      app_rdy = 1'b0;
      abort   = 1'b0;
      if (k == abort_at) break;
    end
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_cmd = 3'b000; req_addr = '0; req_len = '0;
    abort = 1'b0; app_rdy = 1'b1;
    #12;
    check("rst_app_en", app_en, 0);
    check("rst_app_cmd", app_cmd, 0);
    check("rst_app_addr", app_addr, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_done", done, 0);
    check("rst_issued", issued, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    app_rdy = 1'b0;
    chk_en = 1'b1;
    tick();

    run_burst(3'b001, 64'h100, 0, 0, 1'b0, -1);          // single read
    run_burst(3'b000, 64'h200, 3, 2, 1'b0, -1);          // stalled burst
    run_burst(3'b001, 64'h200, 7, 2, 1'b0, 2);           // abort on 3rd
    run_burst(3'b000, 64'h1FFFFFF8, 1, 0, 1'b0, -1);     // address wrap
    run_burst(3'b001, 64'h400, 63, 0, 1'b0, -1);         // max length
    run_burst(3'b000, 64'h500, 2, 1, 1'b0, 2);           // abort on last

    // back-to-back requests with req_valid held high
    app_rdy = 1'b1;
    drive_req(3'b000, 64'h600, 0);
    wait_ready();
    tick();
    drive_req(3'b000, 64'h700, 0);
    wait_ready();
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    app_rdy = 1'b0;

    for (int i = 0; i < 30; i++) begin
      int len;
      int ab;
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 9));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
      run_burst(3'($urandom_range(0, 7)), longint'($urandom_range(0, 32'h1FFFFFFF)),
                len, 2, 1'b1, ab);
    end

    // asynchronous reset in the middle of a stalled burst
    drive_req(3'b001, 64'h300, 3);
    wait_ready();
    tick();
    req_valid = 1'b0;
    tick();
    check("pre_rst_app_en", app_en, 1);
    chk_en = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_app_en", app_en, 0);
    check("async_rst_app_addr", app_addr, 0);
    check("async_rst_busy", busy, 0);
    tick(); tick();
    rstn = 1'b1;
    m_active = 1'b0; m_issued = 0; m_done_exp = 1'b0; m_idx = 0;
    req_q.delete();
    chk_en = 1'b1;
    tick();
    run_burst(3'b000, 64'h800, 1, 1, 1'b0, -1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
